// File: rtl/eit_scan_controller.sv
// eit_scan_controller: frame-level sequencer for one EIT acquisition frame.
// Walks every adjacent drive pair (d, d+1) and every adjacent measurement
// pair (m, m+1) that does not touch the drive electrodes. For each one it
// presents the addresses, waits for the mux to settle, steps slave_fsm and
// waits for fsm_done (bounded by TIMEOUT).
module eit_scan_controller #(
    parameter int N_ELEC        = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 255,
    localparam int EW = $clog2(N_ELEC),
    localparam int MW = $clog2(N_ELEC * (N_ELEC - 3))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scan_start,
    input  logic          scan_abort,
    input  logic          fsm_done,
    input  logic          fsm_busy,
    output logic          slave_step,
    output logic [EW-1:0] drive_src,
    output logic [EW-1:0] drive_sink,
    output logic [EW-1:0] meas_p,
    output logic [EW-1:0] meas_n,
    output logic [MW-1:0] meas_index,
    output logic          meas_valid,
    output logic          frame_done,
    output logic          scan_busy,
    output logic          err_timeout
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SETTLE,
        S_TRIGGER,
        S_WAIT,
        S_ADVANCE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] wait_cnt;
    logic [EW-1:0] last_m;
    logic          last_drive;

    // Last valid measurement electrode for the current drive is d-2 (mod N).
    always_comb begin
        last_m     = drive_src + EW'(N_ELEC - 2);
        last_drive = (drive_src == EW'(N_ELEC - 1));
    end

    // Frame sequencer; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            settle_cnt  <= '0;
            wait_cnt    <= '0;
            slave_step  <= 1'b0;
            drive_src   <= '0;
            drive_sink  <= '0;
            meas_p      <= '0;
            meas_n      <= '0;
            meas_index  <= '0;
            meas_valid  <= 1'b0;
            frame_done  <= 1'b0;
            scan_busy   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            slave_step <= 1'b0;
            meas_valid <= 1'b0;
            frame_done <= 1'b0;
            if (scan_abort) begin
                state     <= S_IDLE;
                scan_busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (scan_start) begin
                            drive_src   <= '0;
                            drive_sink  <= EW'(1);
                            meas_p      <= EW'(2);
                            meas_n      <= EW'(3);
                            meas_index  <= '0;
                            err_timeout <= 1'b0;
                            scan_busy   <= 1'b1;
                            state       <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        settle_cnt <= SW'(SETTLE_CYCLES);
                        state      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SW'(1)) begin
                            // Step is raised on entry so it is visible during TRIGGER.
                            slave_step <= !fsm_busy;
                            state      <= S_TRIGGER;
                        end else begin
                            settle_cnt <= settle_cnt - SW'(1);
                        end
                    end
                    S_TRIGGER: begin
                        if (slave_step) begin
                            wait_cnt <= '0;
                            state    <= S_WAIT;
                        end else begin
                            slave_step <= !fsm_busy;
                        end
                    end
                    S_WAIT: begin
                        if (fsm_done) begin
                            meas_valid <= 1'b1;
                            state      <= S_ADVANCE;
                        end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                            err_timeout <= 1'b1;
                            scan_busy   <= 1'b0;
                            state       <= S_ERROR;
                        end else begin
                            wait_cnt <= wait_cnt + TW'(1);
                        end
                    end
                    S_ADVANCE: begin
                        if (last_drive && meas_p == last_m) begin
                            frame_done <= 1'b1;
                            scan_busy  <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            if (meas_p == last_m) begin
                                drive_src  <= drive_src + EW'(1);
                                drive_sink <= drive_src + EW'(2);
                                meas_p     <= drive_src + EW'(3);
                                meas_n     <= drive_src + EW'(4);
                            end else begin
                                meas_p <= meas_n;
                                meas_n <= meas_n + EW'(1);
                            end
                            meas_index <= meas_index + MW'(1);
                            state      <= S_SETUP;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        scan_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eit_scan_controller.sv
// Directed testbench for eit_scan_controller (N=16, SETTLE=4, TIMEOUT=255).
module tb_eit_scan_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_start;
    logic       scan_abort;
    logic       fsm_done;
    logic       fsm_busy;
    logic       slave_step;
    logic [3:0] drive_src;
    logic [3:0] drive_sink;
    logic [3:0] meas_p;
    logic [3:0] meas_n;
    logic [7:0] meas_index;
    logic       meas_valid;
    logic       frame_done;
    logic       scan_busy;
    logic       err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    // Slave model state (written only by the responder, except control knobs).
    int   step_total = 0;
    int   skip_step  = -1;
    int   abort_idx  = -1;
    int   resp_cnt   = 0;
    logic resp_abort = 1'b0;
    logic main_abort = 1'b0;

    assign scan_abort = resp_abort | main_abort;

    eit_scan_controller #(
        .N_ELEC(16),
        .SETTLE_CYCLES(4),
        .TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .scan_start(scan_start),
        .scan_abort(scan_abort),
        .fsm_done(fsm_done),
        .fsm_busy(fsm_busy),
        .slave_step(slave_step),
        .drive_src(drive_src),
        .drive_sink(drive_sink),
        .meas_p(meas_p),
        .meas_n(meas_n),
        .meas_index(meas_index),
        .meas_valid(meas_valid),
        .frame_done(frame_done),
        .scan_busy(scan_busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // slave_fsm model: answers fsm_done 10 cycles after each slave_step.
    initial begin
        fsm_done = 1'b0;
        fsm_busy = 1'b0;
        forever begin
            @(negedge clk);
            fsm_done   = 1'b0;
            resp_abort = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    fsm_done = 1'b1;
                    if (abort_idx >= 0 && int'(meas_index) == abort_idx) resp_abort = 1'b1;
                end
            end
            if (slave_step) begin
                step_total++;
                if (step_total != skip_step) resp_cnt = 10;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) scan_start = 1'b1;
        @(negedge clk) scan_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({slave_step, meas_valid, frame_done, scan_busy, err_timeout} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {slave_step, meas_valid, frame_done, scan_busy, err_timeout});
        end
        n_cmp++;
        if ({drive_src, drive_sink, meas_p, meas_n} !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_addr: got %h expected 0000", {drive_src, drive_sink, meas_p, meas_n});
        end
        n_cmp++;
        if (meas_index !== 8'd0) begin
            n_err++;
            $display("FAIL reset_index: got %0d expected 0", meas_index);
        end
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({slave_step, meas_valid, frame_done, scan_busy} !== 4'b0) begin
                n_err++;
                $display("FAIL post_reset_idle: got %b expected 0000",
                         {slave_step, meas_valid, frame_done, scan_busy});
            end
        end
    endtask

    // Runs one complete frame, checking every measurement against the
    // adjacent-pattern model; optionally pulses scan_start mid-frame.
    task automatic run_frame(input string tag, input int mid_at);
        int k = 0, ns = 0, nd = 0, post = 0, touch = 0;
        int d, m;
        logic [15:0] exp_addr, got_addr;
        pulse_start();
        for (int cyc = 0; cyc < 10000 && post < 6; cyc++) begin
            @(posedge clk);
            #1;
            scan_start = 1'b0;
            if (slave_step) ns++;
            if (meas_valid) begin
                d = k / 13;
                m = (d + 2 + k % 13) % 16;
                exp_addr = {4'(d), 4'((d + 1) % 16), 4'(m), 4'((m + 1) % 16)};
                got_addr = {drive_src, drive_sink, meas_p, meas_n};
                n_cmp++;
                if (meas_index !== 8'(k)) begin
                    n_err++;
                    $display("FAIL %s_index: got %0d expected %0d", tag, meas_index, k);
                end
                n_cmp++;
                if (got_addr !== exp_addr) begin
                    n_err++;
                    $display("FAIL %s_addr k=%0d: got %h expected %h", tag, k, got_addr, exp_addr);
                end
                if (meas_p == drive_src || meas_p == drive_sink ||
                    meas_n == drive_src || meas_n == drive_sink) touch++;
                if (k == 0 || k == 25 || k == 182 || k == 207) begin
                    case (k)
                        0:       exp_addr = 16'h0123;
                        25:      exp_addr = 16'h12F0;
                        182:     exp_addr = 16'hEF01;
                        default: exp_addr = 16'hF0DE;
                    endcase
                    n_cmp++;
                    if (got_addr !== exp_addr) begin
                        n_err++;
                        $display("FAIL %s_key_pair k=%0d: got %h expected %h", tag, k, got_addr, exp_addr);
                    end
                end
                if (k == mid_at) scan_start = 1'b1;
                k++;
            end
            if (frame_done) begin
                nd++;
                n_cmp++;
                if (k != 208) begin
                    n_err++;
                    $display("FAIL %s_done_early: got %0d measurements expected 208", tag, k);
                end
            end
            if (nd > 0) post++;
        end
        n_cmp++;
        if (post < 6) begin
            n_err++;
            $display("FAIL %s_bound: frame did not finish, got %0d measurements expected 208", tag, k);
        end
        n_cmp++;
        if (k != 208 || ns != 208) begin
            n_err++;
            $display("FAIL %s_counts: got valid=%0d step=%0d expected 208/208", tag, k, ns);
        end
        n_cmp++;
        if (nd != 1) begin
            n_err++;
            $display("FAIL %s_frame_done_count: got %0d expected 1", tag, nd);
        end
        n_cmp++;
        if (touch != 0) begin
            n_err++;
            $display("FAIL %s_touch: got %0d overlapping pairs expected 0", tag, touch);
        end
        n_cmp++;
        if (scan_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_busy_after: got %b expected 0", tag, scan_busy);
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_full_frame();
        run_frame("frame", -1);
    endtask

    task automatic test_mid_start();
        run_frame("midstart", 50);
    endtask

    task automatic test_timeout();
        int ns = 0, nv = 0, nd = 0, t5 = 0, cyc = 0, lat = 0;
        bit got = 0;
        skip_step = step_total + 5;
        pulse_start();
        for (cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            if (slave_step) begin
                ns++;
                if (ns == 5) t5 = cyc;
            end
            if (meas_valid) nv++;
            if (frame_done) nd++;
            if (err_timeout) begin
                got = 1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL timeout_bound: got err_timeout=0 expected 1 within 3000 cycles");
        end
        n_cmp++;
        if (nv != 4 || nd != 0 || meas_index !== 8'd4) begin
            n_err++;
            $display("FAIL timeout_progress: got valid=%0d done=%0d index=%0d expected 4/0/4", nv, nd, meas_index);
        end
        n_cmp++;
        if (cyc - t5 != 256) begin
            n_err++;
            $display("FAIL timeout_delay: got %0d cycles expected 256", cyc - t5);
        end
        n_cmp++;
        if (scan_busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_busy: got %b expected 0", scan_busy);
        end
        // Abort in ERROR must leave the sticky flag alone.
        @(negedge clk) main_abort = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (err_timeout !== 1'b1 || scan_busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_keeps_err: got err=%b busy=%b expected 1/0", err_timeout, scan_busy);
        end
        @(negedge clk) main_abort = 1'b0;
        @(negedge clk) scan_start = 1'b1;
        @(posedge clk);
        #1;
        scan_start = 1'b0;
        n_cmp++;
        if (err_timeout !== 1'b0 || scan_busy !== 1'b1 || meas_index !== 8'd0) begin
            n_err++;
            $display("FAIL restart: got err=%b busy=%b index=%0d expected 0/1/0", err_timeout, scan_busy, meas_index);
        end
        for (lat = 1; lat < 50; lat++) begin
            @(posedge clk);
            #1;
            if (slave_step) break;
        end
        n_cmp++;
        if (lat != 5) begin
            n_err++;
            $display("FAIL start_latency: got %0d expected 5 cycles after accept", lat);
        end
        @(negedge clk) main_abort = 1'b1;
        @(negedge clk) main_abort = 1'b0;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_abort();
        int nv = 0, nd = 0, extra = 0;
        bit idle = 0;
        abort_idx = 40;
        pulse_start();
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(posedge clk);
            #1;
            if (meas_valid) nv++;
            if (frame_done) nd++;
            if (!scan_busy) begin
                idle = 1;
                break;
            end
        end
        abort_idx = -1;
        n_cmp++;
        if (!idle) begin
            n_err++;
            $display("FAIL abort_bound: got scan_busy=1 expected 0 within 5000 cycles");
        end
        n_cmp++;
        if (nv != 40 || nd != 0 || meas_index !== 8'd40 || meas_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state: got valid=%0d done=%0d index=%0d mv=%b expected 40/0/40/0",
                     nv, nd, meas_index, meas_valid);
        end
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (slave_step || meas_valid || frame_done || scan_busy) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL abort_quiet: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_start_with_abort();
        @(negedge clk);
        scan_start = 1'b1;
        main_abort = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (scan_busy !== 1'b0 || slave_step !== 1'b0) begin
            n_err++;
            $display("FAIL start_with_abort: got busy=%b step=%b expected 0/0", scan_busy, slave_step);
        end
        @(negedge clk);
        scan_start = 1'b0;
        main_abort = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (scan_busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_with_abort_idle: got busy=%b expected 0", scan_busy);
        end
    endtask

    initial begin
        rst        = 1'b0;
        scan_start = 1'b0;
        test_reset();
        test_full_frame();
        test_mid_start();
        test_timeout();
        test_abort();
        test_start_with_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
